// File: rtl/ikaopll_wrqueue.sv
// ikaopll_wrqueue: buffers (chip, address, data) register writes for several
// IKAOPLL instances. Each entry becomes an address strobe and a data strobe on
// one shared D/A0/WR_n bus. The bus holds off per-chip until that chip's
// address-to-data and data-to-address recovery times, counted in phiM enables,
// have elapsed.
module ikaopll_wrqueue #(
  parameter int NUM_CHIPS  = 2,
  parameter int CHIP_W     = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int LEVEL_W    = 5,
  parameter int STROBE_CYC = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic                 i_EMUCLK,
  input  logic                 i_RST_n,
  input  logic                 i_phiM_PCEN_n,
  input  logic                 i_WR_VALID,
  output logic                 o_WR_READY,
  input  logic [CHIP_W-1:0]    i_WR_CHIP,
  input  logic [7:0]           i_WR_ADDR,
  input  logic [7:0]           i_WR_DATA,
  input  logic                 i_FLUSH,
  output logic [LEVEL_W-1:0]   o_LEVEL,
  output logic                 o_EMPTY,
  output logic                 o_DROP,
  output logic [NUM_CHIPS-1:0] o_CS_n,
  output logic                 o_WR_n,
  output logic                 o_A0,
  output logic [7:0]           o_D
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int WAIT_W   = ($clog2(MAX_WAIT + 1) > 7) ? $clog2(MAX_WAIT + 1) : 7;
  localparam int STB_W    = $clog2(STROBE_CYC + 1);

  typedef enum logic [1:0] {IDLE, ASTB, AWAIT, DSTB} state_t;

  typedef struct packed {
    logic [CHIP_W-1:0] chip;
    logic [7:0]        addr;
    logic [7:0]        data;
  } entry_t;

  entry_t               mem [FIFO_DEPTH];
  entry_t               head;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_base, wr_base;
  logic [LEVEL_W-1:0]   level, level_base;
  logic [WAIT_W-1:0]    wait_cnt [NUM_CHIPS];
  logic [WAIT_W-1:0]    head_wait;
  logic [NUM_CHIPS-1:0] head_sel;
  logic                 head_in_range;

  state_t               state, state_d;
  logic [STB_W-1:0]     stb_cnt, stb_cnt_d;
  logic                 pop, drop, load_addr_wait, load_data_wait, keep, push;
  logic                 phi_en;
  logic [NUM_CHIPS-1:0] cs_n_d;
  logic                 wr_n_d, a0_d;
  logic [7:0]           d_d;

  assign phi_en     = ~i_phiM_PCEN_n;
  assign head       = mem[rd_ptr];
  assign o_LEVEL    = level;
  assign o_WR_READY = (level != LEVEL_W'(FIFO_DEPTH));
  assign o_EMPTY    = (level == '0) && (state == IDLE);
  assign push       = i_WR_VALID && o_WR_READY;

  // Decode the head entry's chip: range check, one-hot select, its wait count.
  always_comb begin
    head_in_range = 1'b0;
    head_wait     = '0;
    head_sel      = '0;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      if (head.chip == CHIP_W'(c)) begin
        head_in_range = 1'b1;
        head_wait     = wait_cnt[c];
        head_sel[c]   = 1'b1;
      end
    end
  end

  // Sequencer next state and next bus values; the bus holds unless a strobe starts or ends.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d        = state;
    stb_cnt_d      = stb_cnt;
    pop            = 1'b0;
    drop           = 1'b0;
    load_addr_wait = 1'b0;
    load_data_wait = 1'b0;
    cs_n_d         = o_CS_n;
    wr_n_d         = o_WR_n;
    a0_d           = o_A0;
    d_d            = o_D;
    case (state)
      IDLE: begin
        // A flush in this clock empties the queue, so nothing new is started.
        if ((level != '0) && !i_FLUSH) begin
          if (!head_in_range) begin
            pop  = 1'b1;
            drop = 1'b1;
          end else if (head_wait == '0) begin
            d_d       = head.addr;
            a0_d      = 1'b0;
            cs_n_d    = ~head_sel;
            wr_n_d    = 1'b0;
            stb_cnt_d = '0;
            state_d   = ASTB;
          end
        end
      end
      ASTB: begin
        if (phi_en) begin
          if (stb_cnt == STB_W'(STROBE_CYC - 1)) begin
            cs_n_d         = '1;
            wr_n_d         = 1'b1;
            load_addr_wait = 1'b1;
            state_d        = AWAIT;
          end else begin
            stb_cnt_d = stb_cnt + 1'b1;
          end
        end
      end
      AWAIT: begin
        if (head_wait == '0) begin
          d_d       = head.data;
          a0_d      = 1'b1;
          cs_n_d    = ~head_sel;
          wr_n_d    = 1'b0;
          stb_cnt_d = '0;
          state_d   = DSTB;
        end
      end
      DSTB: begin
        if (phi_en) begin
          if (stb_cnt == STB_W'(STROBE_CYC - 1)) begin
            cs_n_d         = '1;
            wr_n_d         = 1'b1;
            load_data_wait = 1'b1;
            pop            = 1'b1;
            state_d        = IDLE;
          end else begin
            stb_cnt_d = stb_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and level bases after pop/flush; a push is then applied on top.
  always_comb begin
    keep = (state != IDLE) && !pop;
    if (i_FLUSH) begin
      rd_base    = rd_ptr + PTR_W'(pop);
      level_base = keep ? LEVEL_W'(1) : '0;
      wr_base    = rd_base + PTR_W'(keep);
    end else begin
      rd_base    = rd_ptr + PTR_W'(pop);
      level_base = level - LEVEL_W'(pop);
      wr_base    = wr_ptr;
    end
  end

  // Sequencer state, strobe counter and registered bus outputs.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state   <= IDLE;
      stb_cnt <= '0;
      o_CS_n  <= '1;
      o_WR_n  <= 1'b1;
      o_A0    <= 1'b0;
      o_D     <= '0;
      o_DROP  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state   <= state_d;
      stb_cnt <= stb_cnt_d;
      o_CS_n  <= cs_n_d;
      o_WR_n  <= wr_n_d;
      o_A0    <= a0_d;
      o_D     <= d_d;
      o_DROP  <= drop;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      rd_ptr <= rd_base;
      if (push) begin
        wr_ptr <= wr_base + 1'b1;
        level  <= level_base + 1'b1;
      end else begin
        wr_ptr <= wr_base;
        level  <= level_base;
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      // NOTE: storage is cleared as well, so an unwritten slot can never put X on the bus.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_base] <= '{chip: i_WR_CHIP, addr: i_WR_ADDR, data: i_WR_DATA};
    end
  end

  // Per-chip recovery counters, loaded at strobe release and drained on phiM enables.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      for (int c = 0; c < NUM_CHIPS; c++) wait_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CHIPS; c++) begin
        if (load_addr_wait && head_sel[c])      wait_cnt[c] <= WAIT_W'(ADDR_WAIT);
        else if (load_data_wait && head_sel[c]) wait_cnt[c] <= WAIT_W'(DATA_WAIT);
        else if (phi_en && (wait_cnt[c] != '0)) wait_cnt[c] <= wait_cnt[c] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ikaopll_wrqueue.sv
// Directed bench for ikaopll_wrqueue: strobe timing, recovery waits, chip
// interleaving, FIFO full handling, out-of-range drop, flush and async reset.
module tb_ikaopll_wrqueue;

  localparam int NUM_CHIPS  = 2;
  localparam int CHIP_W     = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int LEVEL_W    = 5;
  localparam int STROBE_CYC = 2;
  localparam int ADDR_WAIT  = 12;
  localparam int DATA_WAIT  = 84;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pcen_n = 1'b1;
  logic              wr_valid = 1'b0;
  logic              flush = 1'b0;
  logic [CHIP_W-1:0] wr_chip = '0;
  logic [7:0]        wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic              wr_ready, empty, drop, wr_n, a0;
  logic [LEVEL_W-1:0] level;
  logic [NUM_CHIPS-1:0] cs_n;
  logic [7:0]        d;

  ikaopll_wrqueue #(
    .NUM_CHIPS(NUM_CHIPS), .CHIP_W(CHIP_W), .FIFO_DEPTH(FIFO_DEPTH), .LEVEL_W(LEVEL_W),
    .STROBE_CYC(STROBE_CYC), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)
  ) dut (
    .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n),
    .i_WR_VALID(wr_valid), .o_WR_READY(wr_ready), .i_WR_CHIP(wr_chip),
    .i_WR_ADDR(wr_addr), .i_WR_DATA(wr_data), .i_FLUSH(flush),
    .o_LEVEL(level), .o_EMPTY(empty), .o_DROP(drop),
    .o_CS_n(cs_n), .o_WR_n(wr_n), .o_A0(a0), .o_D(d)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int en_cnt = 0;
  int ph_cnt = 0;
  bit pcen_run = 1'b1;

  // Free-running clock and phiM enable counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!pcen_n) en_cnt <= en_cnt + 1;
  end

  // phiM enable on every 4th clock while pcen_run is set.
  initial begin
    forever begin
      @(negedge clk);
      ph_cnt = (ph_cnt + 1) % 4;
      pcen_n = !(pcen_run && (ph_cnt == 0));
    end
  end

  // Strobe log: enable count, cycle and bus state at each WR_n edge.
  int         fall_en [64];
  int         fall_cyc[64];
  int         rise_en [64];
  int         rise_cyc[64];
  logic [7:0] fall_d  [64];
  logic [7:0] rise_d  [64];
  logic       fall_a0 [64];
  logic [1:0] fall_cs [64];
  logic [4:0] fall_lvl[64];
  logic [4:0] rise_lvl[64];
  int         nstb = 0;
  int         two_low = 0;
  int         drop_seen = 0;
  logic       prev_wr = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(~cs_n) > 1) two_low <= two_low + 1;
      if (drop) drop_seen <= drop_seen + 1;
      if (nstb < 64) begin
        if (prev_wr && !wr_n) begin
          fall_en[nstb]  <= en_cnt;
          fall_cyc[nstb] <= cyc;
          fall_d[nstb]   <= d;
          fall_a0[nstb]  <= a0;
          fall_cs[nstb]  <= cs_n;
          fall_lvl[nstb] <= level;
        end
        if (!prev_wr && wr_n) begin
          rise_en[nstb]  <= en_cnt;
          rise_cyc[nstb] <= cyc;
          rise_d[nstb]   <= d;
          rise_lvl[nstb] <= level;
          nstb           <= nstb + 1;
        end
      end
    end
    prev_wr <= wr_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present one entry from a negedge; it is accepted at the following posedge.
  task automatic push(input logic [CHIP_W-1:0] c, input logic [7:0] a, input logic [7:0] v);
    int i = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_chip  = c;
    wr_addr  = a;
    wr_data  = v;
    while (!wr_ready && i < 2000) begin
      @(negedge clk);
      i++;
    end
    vec_cnt++;
    if (wr_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL push_ready: got %b required 1 after %0d clocks", wr_ready, i);
    end
    @(posedge clk);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, input string name);
    int i = 0;
    while (nstb < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    vec_cnt++;
    if (nstb < target) begin
      err_cnt++;
      $display("FAIL %s timeout: got %0d strobes required %0d", name, nstb, target);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (cs_n !== 2'b11) begin err_cnt++; $display("FAIL reset_cs_n: got %b required 11", cs_n); end
    vec_cnt++; if (wr_n !== 1'b1) begin err_cnt++; $display("FAIL reset_wr_n: got %b required 1", wr_n); end
    vec_cnt++; if (a0 !== 1'b0) begin err_cnt++; $display("FAIL reset_a0: got %b required 0", a0); end
    vec_cnt++; if (d !== 8'h00) begin err_cnt++; $display("FAIL reset_d: got %h required 00", d); end
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL reset_level: got %0d required 0", level); end
    vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b required 1", empty); end
    vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready: got %b required 1", wr_ready); end
    vec_cnt++; if (drop !== 1'b0) begin err_cnt++; $display("FAIL reset_drop: got %b required 0", drop); end
  endtask

  task automatic test_single_write();
    int b;
    do_reset();
    b = nstb;
    push(2'd0, 8'h10, 8'h45);
    idle_bus();
    wait_strobes(b + 2, 400, "single");
    vec_cnt++; if (fall_a0[b] !== 1'b0) begin err_cnt++; $display("FAIL single_addr_a0: got %b required 0", fall_a0[b]); end
    vec_cnt++; if (fall_d[b] !== 8'h10) begin err_cnt++; $display("FAIL single_addr_d: got %h required 10", fall_d[b]); end
    vec_cnt++; if (fall_cs[b] !== 2'b10) begin err_cnt++; $display("FAIL single_addr_cs: got %b required 10", fall_cs[b]); end
    vec_cnt++; if (rise_en[b] - fall_en[b] !== 2) begin err_cnt++; $display("FAIL single_addr_width: got %0d required 2", rise_en[b] - fall_en[b]); end
    vec_cnt++; if (rise_d[b] !== 8'h10) begin err_cnt++; $display("FAIL single_bus_hold: got %h required 10", rise_d[b]); end
    vec_cnt++; if (fall_en[b+1] - rise_en[b] !== 12) begin err_cnt++; $display("FAIL single_addr_gap: got %0d required 12", fall_en[b+1] - rise_en[b]); end
    vec_cnt++; if (fall_a0[b+1] !== 1'b1) begin err_cnt++; $display("FAIL single_data_a0: got %b required 1", fall_a0[b+1]); end
    vec_cnt++; if (fall_d[b+1] !== 8'h45) begin err_cnt++; $display("FAIL single_data_d: got %h required 45", fall_d[b+1]); end
    vec_cnt++; if (rise_en[b+1] - fall_en[b+1] !== 2) begin err_cnt++; $display("FAIL single_data_width: got %0d required 2", rise_en[b+1] - fall_en[b+1]); end
    vec_cnt++; if (fall_lvl[b+1] !== 5'd1) begin err_cnt++; $display("FAIL single_level_in_data: got %0d required 1", fall_lvl[b+1]); end
    vec_cnt++; if (rise_lvl[b+1] !== 5'd0) begin err_cnt++; $display("FAIL single_level_release: got %0d required 0", rise_lvl[b+1]); end
    @(negedge clk);
    vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL single_empty: got %b required 1", empty); end
  endtask

  task automatic test_back_to_back();
    int b;
    do_reset();
    b = nstb;
    push(2'd0, 8'h20, 8'h11);
    push(2'd0, 8'h30, 8'h22);
    idle_bus();
    wait_strobes(b + 4, 2000, "b2b");
    vec_cnt++; if (fall_en[b+2] - rise_en[b+1] !== 84) begin err_cnt++; $display("FAIL b2b_data_wait: got %0d required 84", fall_en[b+2] - rise_en[b+1]); end
    vec_cnt++; if (fall_d[b+2] !== 8'h30) begin err_cnt++; $display("FAIL b2b_addr2_d: got %h required 30", fall_d[b+2]); end
    vec_cnt++; if (fall_a0[b+2] !== 1'b0) begin err_cnt++; $display("FAIL b2b_addr2_a0: got %b required 0", fall_a0[b+2]); end
    vec_cnt++; if (fall_d[b+3] !== 8'h22) begin err_cnt++; $display("FAIL b2b_data2_d: got %h required 22", fall_d[b+3]); end
    vec_cnt++; if (fall_a0[b+3] !== 1'b1) begin err_cnt++; $display("FAIL b2b_data2_a0: got %b required 1", fall_a0[b+3]); end
  endtask

  task automatic test_two_chips();
    int b;
    int t;
    do_reset();
    b = nstb;
    t = two_low;
    push(2'd0, 8'h40, 8'h55);
    push(2'd1, 8'h41, 8'h66);
    idle_bus();
    wait_strobes(b + 4, 1000, "chips");
    vec_cnt++; if (fall_cyc[b+2] - rise_cyc[b+1] !== 1) begin err_cnt++; $display("FAIL chips_gap_clocks: got %0d required 1", fall_cyc[b+2] - rise_cyc[b+1]); end
    vec_cnt++; if (fall_cs[b+2] !== 2'b01) begin err_cnt++; $display("FAIL chips_cs1: got %b required 01", fall_cs[b+2]); end
    vec_cnt++; if (fall_d[b+2] !== 8'h41) begin err_cnt++; $display("FAIL chips_addr_d: got %h required 41", fall_d[b+2]); end
    vec_cnt++; if (fall_d[b+3] !== 8'h66) begin err_cnt++; $display("FAIL chips_data_d: got %h required 66", fall_d[b+3]); end
    vec_cnt++; if (two_low - t !== 0) begin err_cnt++; $display("FAIL chips_cs_overlap: got %0d clocks required 0", two_low - t); end
  endtask

  task automatic test_fifo_full();
    int i;
    pcen_run = 1'b0;
    do_reset();
    for (int k = 0; k < 15; k++) push(2'd0, 8'(k), 8'(k + 8'h80));
    #1;
    vec_cnt++; if (level !== 5'd15) begin err_cnt++; $display("FAIL full_level15: got %0d required 15", level); end
    vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL full_ready15: got %b required 1", wr_ready); end
    push(2'd0, 8'h0f, 8'h8f);
    #1;
    vec_cnt++; if (level !== 5'd16) begin err_cnt++; $display("FAIL full_level16: got %0d required 16", level); end
    vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready16: got %b required 0", wr_ready); end
    @(negedge clk);
    wr_addr = 8'hee;
    wr_data = 8'hdd;
    repeat (3) @(negedge clk);
    vec_cnt++; if (level !== 5'd16) begin err_cnt++; $display("FAIL full_held: got %0d required 16", level); end
    pcen_run = 1'b1;
    i = 0;
    while (level == 5'd16 && i < 400) begin
      @(negedge clk);
      i++;
    end
    vec_cnt++; if (level !== 5'd15) begin err_cnt++; $display("FAIL full_after_pop: got %0d required 15", level); end
    vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL full_ready_rise: got %b required 1", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
    vec_cnt++; if (level !== 5'd16) begin err_cnt++; $display("FAIL full_17th_accept: got %0d required 16", level); end
    vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready_fall: got %b required 0", wr_ready); end
  endtask

  task automatic test_drop();
    int b;
    int dr;
    do_reset();
    b  = nstb;
    dr = drop_seen;
    push(2'd3, 8'h50, 8'h77);
    push(2'd1, 8'h51, 8'h88);
    idle_bus();
    wait_strobes(b + 2, 400, "drop");
    vec_cnt++; if (drop_seen - dr !== 1) begin err_cnt++; $display("FAIL drop_pulse_clocks: got %0d required 1", drop_seen - dr); end
    vec_cnt++; if (fall_cs[b] !== 2'b01) begin err_cnt++; $display("FAIL drop_next_cs: got %b required 01", fall_cs[b]); end
    vec_cnt++; if (fall_d[b] !== 8'h51) begin err_cnt++; $display("FAIL drop_next_addr: got %h required 51", fall_d[b]); end
    vec_cnt++; if (fall_d[b+1] !== 8'h88) begin err_cnt++; $display("FAIL drop_next_data: got %h required 88", fall_d[b+1]); end
  endtask

  task automatic test_flush();
    int b;
    do_reset();
    b = nstb;
    push(2'd0, 8'h60, 8'h01);
    push(2'd0, 8'h61, 8'h02);
    push(2'd0, 8'h62, 8'h03);
    idle_bus();
    wait_strobes(b + 1, 200, "flush_addr");
    vec_cnt++; if (level !== 5'd3) begin err_cnt++; $display("FAIL flush_level_before: got %0d required 3", level); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vec_cnt++; if (level !== 5'd1) begin err_cnt++; $display("FAIL flush_level_after: got %0d required 1", level); end
    wait_strobes(b + 2, 200, "flush_data");
    vec_cnt++; if (fall_d[b+1] !== 8'h01) begin err_cnt++; $display("FAIL flush_data_d: got %h required 01", fall_d[b+1]); end
    vec_cnt++; if (fall_a0[b+1] !== 1'b1) begin err_cnt++; $display("FAIL flush_data_a0: got %b required 1", fall_a0[b+1]); end
    vec_cnt++; if (rise_lvl[b+1] !== 5'd0) begin err_cnt++; $display("FAIL flush_level_end: got %0d required 0", rise_lvl[b+1]); end
    repeat (600) @(negedge clk);
    vec_cnt++; if (nstb - b !== 2) begin err_cnt++; $display("FAIL flush_no_more: got %0d strobes required 2", nstb - b); end
    vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL flush_empty: got %b required 1", empty); end
  endtask

  task automatic test_reset_mid_strobe();
    int i = 0;
    do_reset();
    push(2'd1, 8'h70, 8'h99);
    idle_bus();
    while (wr_n && i < 200) begin
      @(negedge clk);
      i++;
    end
    vec_cnt++; if (wr_n !== 1'b0) begin err_cnt++; $display("FAIL rstmid_strobe_start: got %b required 0", wr_n); end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (cs_n !== 2'b11) begin err_cnt++; $display("FAIL rstmid_cs_n: got %b required 11", cs_n); end
    vec_cnt++; if (wr_n !== 1'b1) begin err_cnt++; $display("FAIL rstmid_wr_n: got %b required 1", wr_n); end
    vec_cnt++; if (level !== 5'd0) begin err_cnt++; $display("FAIL rstmid_level: got %0d required 0", level); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    vec_cnt++; if (wr_n !== 1'b1) begin err_cnt++; $display("FAIL rstmid_discarded: got %b required 1", wr_n); end
    vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL rstmid_empty: got %b required 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_two_chips();
    test_fifo_full();
    test_drop();
    test_flush();
    test_reset_mid_strobe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ikaopll_wrqueue.md
Name: ikaopll_wrqueue

Overview:
- Host-side register-write scheduler that drives the CPU bus of up to NUM_CHIPS IKAOPLL instances over one shared D/A0/WR_n bus, with one CS_n per chip.
- Buffers (chip, address, data) write requests in a FIFO and expands each entry into an address cycle and a data cycle.
- Enforces per-chip address-to-data and data-to-next-address recovery times, counted in phiM enables.
- Lets the host issue write bursts without tracking the YM2413 wait states; a busy chip does not stall writes to the others once its entry is retired.

Parameters:
- NUM_CHIPS, 2, number of OPLL instances; CS_n lines; 1..8.
- CHIP_W, 1, width of the chip index field; 2^CHIP_W >= NUM_CHIPS.
- FIFO_DEPTH, 16, number of entries; power of two, 2..256.
- LEVEL_W, 5, width of o_LEVEL; must hold FIFO_DEPTH.
- STROBE_CYC, 2, phiM enables per WR_n/CS_n low pulse; >= 1.
- ADDR_WAIT, 12, phiM enables from address-strobe release until the same chip may take a data strobe.
- DATA_WAIT, 84, phiM enables from data-strobe release until the same chip may take its next address strobe.

Ports:
- i_EMUCLK  in  1  master clock, same as XIN.
- i_RST_n  in  1  asynchronous active-low reset.
- i_phiM_PCEN_n  in  1  phiM positive-edge clock enable, negative logic; all timing counters advance only when low.
- i_WR_VALID  in  1  host write request.
- o_WR_READY  out  1  FIFO can accept an entry.
- i_WR_CHIP  in  CHIP_W  target chip index.
- i_WR_ADDR  in  8  OPLL register address.
- i_WR_DATA  in  8  register data.
- i_FLUSH  in  1  discard queued entries that are not in flight.
- o_LEVEL  out  LEVEL_W  current FIFO occupancy.
- o_EMPTY  out  1  FIFO empty and sequencer idle.
- o_DROP  out  1  one-clock pulse when an entry with an out-of-range chip index is discarded.
- o_CS_n  out  NUM_CHIPS  per-chip chip select, active low.
- o_WR_n  out  1  shared write strobe, active low.
- o_A0  out  1  0 = address cycle, 1 = data cycle.
- o_D  out  8  shared bus data.

Behaviour:
- Clocking and reset:
  - Single clock i_EMUCLK; every register resets asynchronously on i_RST_n low.
  - Reset values: o_CS_n all 1, o_WR_n 1, o_A0 0, o_D 0, o_LEVEL 0, o_EMPTY 1, o_WR_READY 1, o_DROP 0.
  - Reset also sets state IDLE and clears all wait and strobe counters.
  - Reset mid-strobe releases CS_n/WR_n immediately and discards the in-flight entry.
- FIFO:
  - Push when i_WR_VALID & o_WR_READY; o_WR_READY = (level != FIFO_DEPTH).
  - A pop while full raises ready on the following clock; push and pop in the same clock leave the level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - o_LEVEL counts entries in the FIFO, including the in-flight head.
- Wait counters:
  - One counter per chip, each 7 or more bits wide to hold max(ADDR_WAIT, DATA_WAIT).
  - Each nonzero counter decrements by 1 on every clock with i_phiM_PCEN_n low; counters run independently of the FSM state.
- FSM (evaluated every clock; strobe counter advances on phiM enables):
  - IDLE:
    - If the FIFO is non-empty and the head chip index >= NUM_CHIPS: pop the entry, pulse o_DROP, stay in IDLE.
    - Else if the FIFO is non-empty and wait[head chip] == 0: drive o_D = addr, o_A0 = 0, o_CS_n[chip] = 0, o_WR_n = 0; go to ASTB.
  - ASTB: after STROBE_CYC phiM enables, release CS_n/WR_n, load wait[chip] = ADDR_WAIT, go to AWAIT. o_D and o_A0 hold their values.
  - AWAIT: when wait[chip] == 0, drive o_D = data, o_A0 = 1, assert CS_n/WR_n, go to DSTB.
  - DSTB: after STROBE_CYC phiM enables, release strobes, load wait[chip] = DATA_WAIT, pop the head, return to IDLE.
- Bus hold: o_D and o_A0 stay unchanged outside strobes until the next strobe begins.
- Ordering: entries retire strictly in FIFO order. Head-of-line blocking applies only while the head chip is busy.
- Flush: i_FLUSH clears every entry except an in-flight head (state ASTB/AWAIT/DSTB). The in-flight write completes normally. Wait counters are not cleared. A push in the same clock as i_FLUSH is accepted after the flush.
- o_EMPTY = (level == 0) & IDLE.

Test Plan:
- Reset then one push (chip 0, addr 0x10, data 0x45), phiM enable every 4th clock → CS_n[0]/WR_n low for 2 enables with A0=0, D=0x10. Then exactly 12 enables gap. Then 2 enables with A0=1, D=0x45. o_LEVEL goes 1→0 at data-strobe release.
- Back-to-back writes (chip 0, 0x20/0x11), (chip 0, 0x30/0x22) → second address strobe begins exactly 84 enables after the first data-strobe release.
- Writes to chip 0 then chip 1 → chip 1 address strobe starts the clock after the chip 0 data strobe releases, with no 84-enable wait. o_CS_n never has two bits low.
- Push 17 entries into a stalled FIFO (FIFO_DEPTH=16) → o_WR_READY falls after 16 pushes and the 17th is held. After the first pop, ready rises the next clock and the 17th is accepted. o_LEVEL peaks at 16.
- Entry with chip index 3, NUM_CHIPS=2 → no strobe issued, o_DROP high for 1 clock, next entry proceeds.
- Three queued entries, i_FLUSH asserted during AWAIT of the first → first completes its data strobe, o_LEVEL drops to 1 then to 0, no further strobes. Separately, i_RST_n low during ASTB → all CS_n/WR_n high asynchronously and o_LEVEL = 0.
